// File: rtl/uart_pkg.sv
// Shared UART types and helpers: parity mode, receiver states, parity and majority functions.
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    // Narrower words are zero-extended by the caller; zeros do not change the XOR.
    function automatic logic parity_calc(input logic [8:0] data, input parity_t mode);
        logic result;
        case (mode)
            PARITY_EVEN: result = ^data;
            PARITY_ODD:  result = ~^data;
            default:     result = 1'b0;
        endcase
        return result;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Two-flop synchronizer for a single asynchronous input; latency 2 cycles, no backpressure.
module bit_synchronizer #(
    parameter logic ResetValue = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic async_bit,
    output logic sync_bit
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta     <= ResetValue;
            sync_bit <= ResetValue;
        end else begin
            meta     <= async_bit;
            sync_bit <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART frame receiver; UART_RX_MAJORITY_EN enables 2-of-3 voting at each sample point (one cycle later).
// Delivers each word as a one-cycle pulse with qualified error flags; no backpressure, consumer must accept.
module uart_rx
    import uart_pkg::*;
#(
    parameter int ClockDivider = 8,
    parameter int DataBits     = 8,
    parameter int StopBits     = 1,
    parameter int Parity       = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_bit,
    output logic [DataBits-1:0] data_out,
    output logic                data_out_valid,
    output logic                parity_error,
    output logic                frame_error,
    output logic                busy
);

    localparam int ClockDivBits = $clog2(ClockDivider);
    localparam int MidCount     = (ClockDivider - 1) / 2;
    localparam int IdxBits      = 4;
`ifdef UART_RX_MAJORITY_EN
    localparam int SampleDelay  = 1;
`else
    localparam int SampleDelay  = 0;
`endif
    localparam logic [ClockDivBits-1:0] StartPoint = ClockDivBits'(MidCount + SampleDelay);
    localparam logic [ClockDivBits-1:0] BitPoint   = ClockDivBits'(ClockDivider - 1);
    localparam logic [IdxBits-1:0]      LastIdx    = IdxBits'(DataBits - 1);
    localparam logic                    LastStop   = 1'(StopBits - 1);
    localparam logic [1:0]              ParityCode = Parity[1:0];
    localparam parity_t                 ParityMode = parity_t'(ParityCode);
    localparam logic                    HasParity  = (Parity != 0);

    if (DataBits < 5 || DataBits > 9) begin : g_bad_data_bits
        $error("uart_rx: DataBits must be in [5,9]");
    end
    if (StopBits < 1 || StopBits > 2) begin : g_bad_stop_bits
        $error("uart_rx: StopBits must be 1 or 2");
    end
    if (Parity < 0 || Parity > 2) begin : g_bad_parity
        $error("uart_rx: Parity must be 0, 1 or 2");
    end
    if (ClockDivider < 4) begin : g_bad_divider
        $error("uart_rx: ClockDivider must be >= 4");
    end

    logic                    rx_s;
    logic                    sample_bit;
    logic                    frame_nxt;
    rx_state_t               state;
    logic [ClockDivBits-1:0] cnt;
    logic [IdxBits-1:0]      bit_idx;
    logic                    stop_idx;
    logic [DataBits-1:0]     word;
    logic                    parity_pend;
    logic                    frame_pend;

    bit_synchronizer #(
        .ResetValue (1'b1)
    ) u_sync (
        .clk       (clk),
        .rst       (rst),
        .async_bit (in_bit),
        .sync_bit  (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    logic rx_d1;
    logic rx_d2;

    // Sampling one cycle late lets rx_d1 sit at the nominal point, flanked by rx_d2 and rx_s.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_d1 <= 1'b1;
            rx_d2 <= 1'b1;
        end else begin
            rx_d1 <= rx_s;
            rx_d2 <= rx_d1;
        end
    end
`endif

    always_comb begin
`ifdef UART_RX_MAJORITY_EN
        sample_bit = majority3(rx_s, rx_d1, rx_d2);
`else
        sample_bit = rx_s;
`endif
        frame_nxt = frame_pend | ~sample_bit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            bit_idx        <= '0;
            stop_idx       <= 1'b0;
            word           <= '0;
            parity_pend    <= 1'b0;
            frame_pend     <= 1'b0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            parity_error   <= 1'b0;
            frame_error    <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_out_valid <= 1'b0;
            parity_error   <= 1'b0;
            frame_error    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state       <= ST_START;
                        busy        <= 1'b1;
                        parity_pend <= 1'b0;
                        frame_pend  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (cnt == StartPoint) begin
                        cnt <= '0;
                        if (sample_bit) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= ST_DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + ClockDivBits'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt == BitPoint) begin
                        cnt     <= '0;
                        word    <= {sample_bit, word[DataBits-1:1]};
                        bit_idx <= bit_idx + IdxBits'(1);
                        if (bit_idx == LastIdx) begin
                            stop_idx <= 1'b0;
                            state    <= HasParity ? ST_PARITY : ST_STOP;
                        end
                    end else begin
                        cnt <= cnt + ClockDivBits'(1);
                    end
                end
                ST_PARITY: begin
                    if (cnt == BitPoint) begin
                        cnt         <= '0;
                        parity_pend <= (sample_bit != parity_calc(9'(word), ParityMode));
                        state       <= ST_STOP;
                    end else begin
                        cnt <= cnt + ClockDivBits'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt == BitPoint) begin
                        cnt <= '0;
                        if (stop_idx == LastStop) begin
                            data_out       <= word;
                            data_out_valid <= 1'b1;
                            parity_error   <= parity_pend;
                            frame_error    <= frame_nxt;
                            // Leave half a bit early so a back-to-back start edge is not missed.
                            if (frame_nxt && !rx_s) begin
                                state <= ST_BREAK;
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            stop_idx   <= 1'b1;
                            frame_pend <= frame_nxt;
                        end
                    end else begin
                        cnt <= cnt + ClockDivBits'(1);
                    end
                end
                ST_BREAK: begin
                    if (rx_s) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one instance without parity, one with even parity, each on its own line.
module tb_uart_rx;

    localparam int Div = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       line0 = 1'b1;
    logic       line1 = 1'b1;

    logic [7:0] dout0;
    logic       vld0, pe0, fe0, busy0;
    logic [7:0] dout1;
    logic       vld1, pe1, fe1, busy1;

    logic [9:0] cap0[$];
    logic [9:0] cap1[$];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    uart_rx #(
        .ClockDivider (Div),
        .DataBits     (8),
        .StopBits     (1),
        .Parity       (0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_bit         (line0),
        .data_out       (dout0),
        .data_out_valid (vld0),
        .parity_error   (pe0),
        .frame_error    (fe0),
        .busy           (busy0)
    );

    uart_rx #(
        .ClockDivider (Div),
        .DataBits     (8),
        .StopBits     (1),
        .Parity       (1)
    ) dut_par (
        .clk            (clk),
        .rst            (rst),
        .in_bit         (line1),
        .data_out       (dout1),
        .data_out_valid (vld1),
        .parity_error   (pe1),
        .frame_error    (fe1),
        .busy           (busy1)
    );

    // Every delivered word is recorded as {parity_error, frame_error, data}.
    always @(negedge clk) begin
        if (vld0) cap0.push_back({pe0, fe0, dout0});
        if (vld1) cap1.push_back({pe1, fe1, dout1});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input int sel, input logic b);
        if (sel == 0) line0 = b;
        else line1 = b;
        wait_cycles(Div);
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input logic par_en,
                              input logic par_val, input logic stop_val);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
        if (par_en) drive_bit(sel, par_val);
        drive_bit(sel, stop_val);
    endtask

    initial begin
        // Reset values
        wait_cycles(5);
        check("rst_data_out", 32'(dout0), 32'h00);
        check("rst_valid", 32'(vld0), 32'h0);
        check("rst_parity_error", 32'(pe0), 32'h0);
        check("rst_frame_error", 32'(fe0), 32'h0);
        check("rst_busy", 32'(busy0), 32'h0);
        check("rst_busy_par", 32'(busy1), 32'h0);
        rst = 1'b0;
        wait_cycles(4);

        // Single clean frame
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        wait_cycles(12);
        check("a5_count", 32'(cap0.size()), 32'd1);
        if (cap0.size() > 0) check("a5_word", 32'(cap0[0]), 32'h0A5);
        check("a5_data_out_held", 32'(dout0), 32'hA5);
        check("a5_busy_after", 32'(busy0), 32'h0);
        cap0.delete();

        // Back-to-back frames, transmitter style
        send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
        wait_cycles(12);
        check("b2b_count", 32'(cap0.size()), 32'd3);
        if (cap0.size() == 3) begin
            check("b2b_word0", 32'(cap0[0]), 32'h000);
            check("b2b_word1", 32'(cap0[1]), 32'h0FF);
            check("b2b_word2", 32'(cap0[2]), 32'h055);
        end
        cap0.delete();

        // Two-cycle low glitch on an idle line
        line0 = 1'b0;
        wait_cycles(2);
        line0 = 1'b1;
        wait_cycles(4);
        check("glitch_busy_seen", 32'(busy0), 32'h1);
        wait_cycles(36);
        check("glitch_count", 32'(cap0.size()), 32'd0);
        check("glitch_busy_after", 32'(busy0), 32'h0);

        // Even parity: 0x03 needs parity bit 0
        send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1);
        send_frame(1, 8'h03, 1'b1, 1'b0, 1'b1);
        wait_cycles(12);
        check("par_count", 32'(cap1.size()), 32'd2);
        if (cap1.size() == 2) begin
            check("par_bad_word", 32'(cap1[0]), 32'h203);
            check("par_good_word", 32'(cap1[1]), 32'h003);
        end
        cap1.delete();

        // Stop bit 0 followed by a held-low line, then a clean frame
        send_frame(0, 8'h96, 1'b0, 1'b0, 1'b0);
        wait_cycles(40);
        check("break_count_low", 32'(cap0.size()), 32'd1);
        if (cap0.size() > 0) check("break_word", 32'(cap0[0]), 32'h196);
        check("break_busy_low", 32'(busy0), 32'h1);
        line0 = 1'b1;
        wait_cycles(16);
        check("break_busy_released", 32'(busy0), 32'h0);
        cap0.delete();
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        wait_cycles(12);
        check("after_break_count", 32'(cap0.size()), 32'd1);
        if (cap0.size() > 0) check("after_break_word", 32'(cap0[0]), 32'h03C);
        cap0.delete();

        // Reset during the data bits of 0x81
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, i == 0);
        rst = 1'b1;
        line0 = 1'b1;
        wait_cycles(3);
        check("midrst_data_out", 32'(dout0), 32'h00);
        check("midrst_valid", 32'(vld0), 32'h0);
        check("midrst_busy", 32'(busy0), 32'h0);
        rst = 1'b0;
        wait_cycles(60);
        check("midrst_no_pulse", 32'(cap0.size()), 32'd0);
        check("midrst_idle_busy", 32'(busy0), 32'h0);
        send_frame(0, 8'h42, 1'b0, 1'b0, 1'b1);
        wait_cycles(12);
        check("post_rst_count", 32'(cap0.size()), 32'd1);
        if (cap0.size() > 0) check("post_rst_word", 32'(cap0[0]), 32'h042);
        check("post_rst_valid_low", 32'(vld0), 32'h0);
        check("post_rst_flags_low", 32'({pe0, fe0}), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver; the downstream counterpart of the team's uart_tx.
- Samples an asynchronous serial line and reassembles frames: 1 start bit, DataBits data bits LSB first, optional parity bit, StopBits stop bits.
- Presents each received word as a one-cycle valid pulse, with parity and framing error flags, to the consuming logic (FIFO or CSR block).
- Line timing matches uart_tx with the same ClockDivider: one bit lasts ClockDivider clk cycles.

Parameters:
ClockDivider, 8, clk cycles per serial bit; must be >= 4
DataBits, 8, data bits per frame, range [5,9]
StopBits, 1, stop bits checked, 1 or 2
Parity, 0, 0 = none, 1 = even, 2 = odd

Ports:
clk  input  1  system clock, single clock domain
rst  input  1  synchronous, active-high reset
in_bit  input  1  asynchronous serial line, idle high
data_out  output  DataBits  last received word; held until next frame completes
data_out_valid  output  1  one-cycle pulse when data_out updates
parity_error  output  1  parity mismatch of the delivered word; qualified by data_out_valid
frame_error  output  1  a stop bit sampled 0; qualified by data_out_valid
busy  output  1  high in any state except IDLE

Behaviour:
- Reset: sync flops go to 1, state goes to IDLE, counters go to 0. data_out=0, data_out_valid=0, parity_error=0, frame_error=0, busy=0.
- Elaboration: $error if DataBits is outside [5,9], StopBits is outside [1,2], Parity is outside [0,2], or ClockDivider < 4.
- in_bit passes through a 2-flop synchronizer; all logic uses the synced bit rx_s.
- Counter: ClockDivBits wide, counts 0..ClockDivider-1. MidCount = (ClockDivider-1)/2.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: when rx_s==0, go to START with counter=0.
- START: sample when counter==MidCount.
  - Sample 1: false start, return to IDLE. No output.
  - Sample 0: go to DATA with counter=0 and bit_idx=0.
- DATA: sample when counter==ClockDivider-1, i.e. the middle of each following bit. Shift the sample in at the MSB (shift right) so the word is LSB first. After bit_idx==DataBits-1, go to PARITY if Parity!=0, else to STOP.
- PARITY: one sample. Expected bit: even = ^data, odd = ~^data, the same rule uart_tx uses. A mismatch sets a pending parity flag.
- STOP: StopBits samples. Any 0 sample sets a pending frame flag.
- Delivery: on the cycle after the last stop sample, in a single cycle:
  - data_out_valid=1, data_out=word;
  - parity_error and frame_error take the pending flags.
- After the last stop sample:
  - Go straight to IDLE, so a back-to-back start bit half a bit later is caught.
  - If frame error and rx_s==0, go to BREAK instead.
- BREAK: stay until rx_s==1, then go to IDLE. No new frame is detected while the line is held low.
- Errors never suppress delivery; a frame with errors is still presented.
- Latency: the falling edge on in_bit to data_out_valid is 2 synchronizer cycles plus MidCount + (DataBits+ParityBits+StopBits)*ClockDivider + 1 cycles.
- Reset asserted mid-frame: abort immediately; no valid pulse for the aborted frame.
- Error flags are 0 whenever data_out_valid is 0.
- No backpressure. The consumer must accept the pulse. data_out is stable for at least one frame time after it.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each sample point takes the 2-of-3 majority of rx_s at the sample cycle, the cycle before and the cycle after. The decision is registered at the same sample cycle using a 2-deep rx_s history, so the sample point moves one cycle later and delivery is 1 cycle later. A single-cycle glitch at a sample point is rejected.
- Undefined: a single sample of rx_s at the point given in Behaviour.

Decomposition:
- Package uart_pkg:
  - parity_t enum (PARITY_NONE, PARITY_EVEN, PARITY_ODD);
  - uart_rx state enum;
  - parity function shared with uart_tx.
- Sub-module bit_synchronizer: 2-flop synchronizer, parameter ResetValue=1, for reuse on other async inputs.

Test Plan:
- Parameters ClockDivider=8, DataBits=8, Parity=0. Drive 0xA5 frame -> single valid pulse, data_out=0xA5, both error flags 0, busy low afterwards.
- Loopback from uart_tx with the same parameters. Send 0x00, 0xFF, 0x55 back-to-back -> three valid pulses in order, no errors, no lost frames.
- Idle line with a 2-cycle low glitch -> START rejects it at MidCount, returns to IDLE, no valid pulse.
- Parity=1, send 0x03 with parity bit 1 -> valid pulse with data_out=0x03 and parity_error=1. Correct parity bit 0 -> parity_error=0.
- Stop bit driven 0, line then held low for 40 cycles, then high, then frame 0x3C:
  - first frame: valid pulse with frame_error=1;
  - no frame detected while the line is low;
  - 0x3C received cleanly.
- Assert rst halfway through the data bits of 0x81 -> no valid pulse, outputs at reset values. The next 0x42 frame is received correctly.
